pixel_column_streamer: RTL and testbench
========================================

# pixel_column_streamer

Source side of the edge-detection chip's three-row pixel input. Accepts a raster-order 5-bit pixel stream and buffers two image rows. For each output row it emits one vertical 3-pixel column per cycle on `pixel_in0/1/2` (rows r-1, r, r+1), with zero padding around the image, and marks the last column of each band with `load_end`. It sits between the frame source and the chip, which consumes one column per cycle.

## Interface
- `IMG_W`, 100, image width in pixels (≥2)
- `IMG_H`, 100, image height in rows (≥2)
- `PIX_W`, 5, pixel width in bits
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins a frame; ignored unless the block is idle
- `in_valid`  in  1  `in_pixel` valid
- `in_ready`  out  1  block accepts `in_pixel` this cycle
- `in_pixel`  in  PIX_W  raster-order input pixel
- `out_valid`  out  1  column on `pixel_in0..2` is valid
- `pixel_in0`  out  PIX_W  row r-1 pixel (top)
- `pixel_in1`  out  PIX_W  row r pixel (middle)
- `pixel_in2`  out  PIX_W  row r+1 pixel (bottom)
- `load_end`  out  1  high with the last column of each band
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse after the last column of the last band

## Operation
- FSM states: IDLE, FILL, PAD_L, STREAM, PAD_R, DONE.
- IDLE: `start` moves the FSM to FILL. `busy` is high in every state except IDLE.
- FILL: `in_ready`=1. Accepts IMG_W pixels of row 0 into row buffer B. Top buffer T is treated as all-zero for band 0. No output in this state. Goes to PAD_L.
- PAD_L: emits column (0,0,0). Goes to STREAM.
- STREAM, band r, column c = 0..IMG_W-1:
  - If r < IMG_H-1, `in_ready`=1. On `in_valid & in_ready`, emits (T[c], B[c], in_pixel) and writes in_pixel to the spare buffer at c.
  - If r = IMG_H-1, `in_ready`=0. Emits (T[c], B[c], 0) every cycle without waiting on `in_valid`.
  - With `in_valid`=0 and r < IMG_H-1, no column is emitted and c holds.
  - After column IMG_W-1, goes to PAD_R.
- PAD_R: emits (0,0,0) with `load_end`=1. Then rotates buffers: T←B, B←spare, and clears the band-0 zero-top flag.
  - r < IMG_H-1: increments r and goes to PAD_L.
  - Otherwise: goes to DONE.
- DONE: pulses `frame_done` for one cycle and returns to IDLE.
- Row buffers: three IMG_W×PIX_W arrays, ping-pong rotated by 2-bit pointer index only; data is never copied.
- Counters: c is ⌈log2 IMG_W⌉ bits, r is ⌈log2 IMG_H⌉ bits. Both clear on entry to FILL.
- `start` during busy is ignored. `in_valid` during IDLE/PAD/DONE is ignored, since `in_ready`=0.
- Reset mid-frame: aborts immediately to IDLE. Buffer contents are not cleared; the next FILL overwrites them.

## Timing
- Reset values: `in_ready`, `out_valid`, `pixel_in0..2`, `load_end`, `busy`, `frame_done` all 0. State is IDLE.
- All outputs except `in_ready` are registered. A column appears one cycle after the cycle in which the FSM decides to emit it. `in_ready` is combinational from state and r.
- `start` at edge k: `in_ready`=1 from cycle k+1.
- FILL with continuous valid lasts IMG_W cycles.
- Band with continuous input: IMG_W+2 consecutive `out_valid` cycles, no gaps.
- Whole frame with no stalls: IMG_W + IMG_H·(IMG_W+2) + 1 cycles from start to `frame_done`.
- `pixel_in0..2` are 0 whenever `out_valid`=0.

## Configuration
- `PIXEL_STREAMER_PAD_EN` defined: PAD_L and PAD_R are present. Each band is IMG_W+2 columns, and `load_end` falls on the trailing zero column.
- Undefined: PAD_L and PAD_R are skipped. Each band is IMG_W columns, and `load_end` is asserted with data column IMG_W-1. The buffer rotation moves to the last STREAM cycle. Top and bottom zero rows remain in both builds.

## Test plan
- IMG_W=3, IMG_H=2, PAD_EN, input 1,2,3,4,5,6 with valid held high → band 0: (0,0,0),(0,1,4),(0,2,5),(0,3,6),(0,0,0)+load_end; band 1: (0,0,0),(1,4,0),(2,5,0),(3,6,0),(0,0,0)+load_end; `frame_done` one cycle later.
- Same stimulus, PAD_EN undefined → band 0: (0,1,4),(0,2,5),(0,3,6)+load_end; band 1: (1,4,0),(2,5,0),(3,6,0)+load_end.
- Stall: drop `in_valid` for 2 cycles mid-band-0 → `out_valid` low for exactly 2 cycles, and column order and values are unchanged.
- `start` pulsed during STREAM → ignored, and frame output is identical to the unstalled run.
- `reset` asserted during band 1, then a new frame with pixels 7..12 → all outputs 0 during reset; the new frame's outputs contain only values 7..12 and zeros.
- IMG_W=4, IMG_H=3, 31-valued pixels → band 1 column (31,31,31), confirming no overflow and correct T/B rotation across three bands.

Source files
------------

// File: rtl/pixel_column_streamer_if.sv
// Pixel stream in, 3-row column out, plus frame control/status.
// master = frame source/consumer side, slave = pixel_column_streamer.
interface pixel_column_streamer_if #(
  parameter int PIX_W = 5
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic [PIX_W-1:0] pixel_in0;
  logic [PIX_W-1:0] pixel_in1;
  logic [PIX_W-1:0] pixel_in2;
  logic             load_end;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, in_valid, in_pixel,
    input  in_ready, out_valid,
    input  pixel_in0, pixel_in1, pixel_in2,
    input  load_end, busy, frame_done
  );

  modport slave (
    input  start, in_valid, in_pixel,
    output in_ready, out_valid,
    output pixel_in0, pixel_in1, pixel_in2,
    output load_end, busy, frame_done
  );
endinterface

// File: rtl/pixel_column_streamer.sv
// Buffers two rows and streams zero-padded 3-pixel columns per band.
// PIXEL_STREAMER_PAD_EN adds a zero column on each side of every band.
module pixel_column_streamer #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100,
  parameter int PIX_W = 5
) (
  input logic clk,
  input logic reset,
  pixel_column_streamer_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_PAD_L  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_PAD_R  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       r_state;
  logic [CW-1:0]    r_c;
  logic [RW-1:0]    r_r;
  logic [1:0]       r_pt, r_pb, r_ps;
  logic             r_top_zero;
  logic             r_busy;
  logic             r_out_valid;
  logic [PIX_W-1:0] r_p0, r_p1, r_p2;
  logic             r_load_end;
  logic             r_frame_done;
  logic [PIX_W-1:0] r_buf [3][IMG_W];

  logic             w_last_row;
  logic             w_last_col;
  logic             w_ready;
  logic             w_take;
  logic             w_emit;
  logic [1:0]       w_wr_ptr;
  logic [PIX_W-1:0] w_top, w_mid, w_bot;

  assign w_last_row = (r_r == R_LAST);
  assign w_last_col = (r_c == C_LAST);
  assign w_ready    = (r_state == S_FILL) |
                      ((r_state == S_STREAM) & ~w_last_row);
  assign w_take     = bus.in_valid & w_ready;
  // The bottom row of the last band is padding, so it never waits on input.
  assign w_emit     = (r_state == S_STREAM) &
                      (w_last_row | bus.in_valid);
  assign w_wr_ptr   = (r_state == S_FILL) ? r_pb : r_ps;
  assign w_top      = r_top_zero ? '0 : r_buf[r_pt][r_c];
  assign w_mid      = r_buf[r_pb][r_c];
  assign w_bot      = w_last_row ? '0 : bus.in_pixel;

  assign bus.in_ready   = w_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.pixel_in0  = r_p0;
  assign bus.pixel_in1  = r_p1;
  assign bus.pixel_in2  = r_p2;
  assign bus.load_end   = r_load_end;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

  always_ff @(posedge clk) begin
    if (w_take) r_buf[w_wr_ptr][r_c] <= bus.in_pixel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_c          <= '0;
      r_r          <= '0;
      r_pt         <= 2'd0;
      r_pb         <= 2'd1;
      r_ps         <= 2'd2;
      r_top_zero   <= 1'b1;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_p0         <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
      r_load_end   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_p0         <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
      r_load_end   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_FILL;
            r_busy     <= 1'b1;
            r_c        <= '0;
            r_r        <= '0;
            r_pt       <= 2'd0;
            r_pb       <= 2'd1;
            r_ps       <= 2'd2;
            r_top_zero <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.in_valid) begin
            if (w_last_col) begin
              r_c <= '0;
`ifdef PIXEL_STREAMER_PAD_EN
              r_state <= S_PAD_L;
`else
              r_state <= S_STREAM;
`endif
            end else begin
              r_c <= r_c + CW'(1);
            end
          end
        end
`ifdef PIXEL_STREAMER_PAD_EN
        S_PAD_L: begin
          r_out_valid <= 1'b1;
          r_state     <= S_STREAM;
        end
`endif
        S_STREAM: begin
          if (w_emit) begin
            r_out_valid <= 1'b1;
            r_p0        <= w_top;
            r_p1        <= w_mid;
            r_p2        <= w_bot;
            if (w_last_col) begin
              r_c <= '0;
`ifdef PIXEL_STREAMER_PAD_EN
              r_state <= S_PAD_R;
`else
              r_load_end <= 1'b1;
              r_pt       <= r_pb;
              r_pb       <= r_ps;
              r_ps       <= r_pt;
              r_top_zero <= 1'b0;
              if (w_last_row) r_state <= S_DONE;
              else            r_r     <= r_r + RW'(1);
`endif
            end else begin
              r_c <= r_c + CW'(1);
            end
          end
        end
`ifdef PIXEL_STREAMER_PAD_EN
        S_PAD_R: begin
          r_out_valid <= 1'b1;
          r_load_end  <= 1'b1;
          r_pt        <= r_pb;
          r_pb        <= r_ps;
          r_ps        <= r_pt;
          r_top_zero  <= 1'b0;
          if (w_last_row) begin
            r_state <= S_DONE;
          end else begin
            r_r     <= r_r + RW'(1);
            r_state <= S_PAD_L;
          end
        end
`endif
        S_DONE: begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_column_streamer.sv
// Random frames through pixel_column_streamer vs an image-level column model.
// Builds with or without PIXEL_STREAMER_PAD_EN.
module tb_pixel_column_streamer;
  localparam int W = 4;
  localparam int H = 3;
  localparam int PW = 5;
`ifdef PIXEL_STREAMER_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int BAND = W + 2 * PAD;
  localparam int LAT = W + H * BAND + 1;
  localparam int NPIX = W * H;

  typedef logic [3*PW:0] col_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pixel_column_streamer_if #(.PIX_W(PW)) u_if ();

  pixel_column_streamer #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  col_t          q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            t_done = -1;
  bit            done_next = 1'b0;
  bit            m_ed;
  col_t          m_act, m_e;
  logic [PW-1:0] img [H][W];

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      m_ed = done_next;
      done_next = 1'b0;
      check_eq("frame_done", 32'(u_if.frame_done), 32'(m_ed));
      if (u_if.frame_done) t_done = cyc;
      m_act = {u_if.pixel_in0, u_if.pixel_in1, u_if.pixel_in2, u_if.load_end};
      if (u_if.out_valid) begin
        if (q.size() == 0) begin
          check_eq("spurious_col", 32'(u_if.out_valid), 0);
        end else begin
          m_e = q.pop_front();
          check_eq("column", 32'(m_act), 32'(m_e));
          if (q.size() == 0) done_next = 1'b1;
        end
      end else begin
        check_eq("idle_zero", 32'(m_act), 0);
      end
    end
  end

  task automatic build_expect();
    logic [PW-1:0] top, bot;
    q.delete();
    done_next = 1'b0;
    for (int r = 0; r < H; r++) begin
      if (PAD != 0) q.push_back('0);
      for (int c = 0; c < W; c++) begin
        top = (r > 0) ? img[r-1][c] : '0;
        bot = (r < H - 1) ? img[r+1][c] : '0;
        q.push_back({top, img[r][c], bot, (PAD == 0) && (c == W - 1)});
      end
      if (PAD != 0) q.push_back(col_t'(1));
    end
  endtask

  task automatic run_frame(input int mode, input int stall_pct,
                           input bit poke, input int rst_at);
    int idx, guard, t0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = PW'(1 + r * W + c);
          2:       img[r][c] = PW'(31);
          3:       img[r][c] = PW'(7 + r * W + c);
          default: img[r][c] = PW'($urandom_range(31));
        endcase
    build_expect();
    t_done = -1;
    @(negedge clk);
    u_if.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    u_if.start = 1'b0;
    check_eq("rdy_after_start", 32'(u_if.in_ready), 1);
    check_eq("busy_after_start", 32'(u_if.busy), 1);
    idx = 0;
    guard = 0;
    while (idx < NPIX && guard < 4000) begin
      if (idx == rst_at) begin
        u_if.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_outs", 32'({u_if.out_valid, u_if.pixel_in0,
                 u_if.pixel_in1, u_if.pixel_in2, u_if.load_end,
                 u_if.busy, u_if.frame_done, u_if.in_ready}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        done_next = 1'b0;
        return;
      end
      u_if.start = poke && (idx == NPIX / 2);
      if ($urandom_range(99) < stall_pct) begin
        u_if.in_valid = 1'b0;
      end else begin
        u_if.in_valid = 1'b1;
        u_if.in_pixel = img[idx / W][idx % W];
      end
      if (u_if.in_valid && u_if.in_ready) idx++;
      @(negedge clk);
      guard++;
    end
    u_if.in_valid = 1'b0;
    u_if.start = 1'b0;
    check_eq("pixels_taken", idx, NPIX);
    guard = 0;
    while ((q.size() != 0 || done_next || u_if.busy) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check_eq("frame_drain", q.size(), 0);
    check_eq("idle_busy", 32'(u_if.busy), 0);
    if (stall_pct == 0) check_eq("latency", t_done - t0 - 1, LAT);
  endtask

  initial begin
    u_if.start = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_pixel = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(u_if.out_valid), 0);
    check_eq("rst_in_ready", 32'(u_if.in_ready), 0);
    check_eq("rst_busy", 32'(u_if.busy), 0);
    check_eq("rst_frame_done", 32'(u_if.frame_done), 0);
    check_eq("rst_cols", 32'({u_if.pixel_in0, u_if.pixel_in1,
             u_if.pixel_in2, u_if.load_end}), 0);
    reset = 1'b0;
    run_frame(0, 0, 1'b0, -1);
    run_frame(1, 30, 1'b1, -1);
    run_frame(2, 0, 1'b0, -1);
    run_frame(1, 0, 1'b1, -1);
    run_frame(1, 25, 1'b0, 2 * W + 1);
    run_frame(3, 0, 1'b0, -1);
    repeat (6) run_frame(1, 40, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
